// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller:
// FSM states, ALU codes, opcodes and datapath mux selects.
package multicycle_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALR     = 4'd11,
      S_UPPER    = 4'd12,
      S_TRAP     = 4'd13
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLTU = 4'b0110;
   localparam logic [3:0] ALU_SLL  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // Flags come from rs1 - rs2 computed in the BRANCH cycle.
   function automatic logic branch_taken(
      input logic [2:0] f3,
      input logic       zero,
      input logic       lt,
      input logic       ltu
   );
      logic t;
      t = 1'b0;
      case (f3)
         3'b000:  t = zero;
         3'b001:  t = !zero;
         3'b100:  t = lt;
         3'b101:  t = !lt;
         3'b110:  t = ltu;
         3'b111:  t = !ltu;
         default: t = 1'b0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// ALU operation decode: ALUOp plus funct fields -> 4-bit
// ALU control code shared by R-type and OP-IMM.
module mc_alu_decode
   import multicycle_ctrl_pkg::*;
(
   input  aluop_t     aluop,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op5,
   output logic [3:0] alu_ctrl
);

   always_comb begin
      alu_ctrl = ALU_ADD;
      unique case (aluop)
         ALUOP_ADD: alu_ctrl = ALU_ADD;
         ALUOP_SUB: alu_ctrl = ALU_SUB;
         ALUOP_FUNCT: begin
            unique case (funct3)
               // bit 30 is an immediate bit for ADDI
               3'b000: alu_ctrl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
               3'b001: alu_ctrl = ALU_SLL;
               3'b010: alu_ctrl = ALU_SLT;
               3'b011: alu_ctrl = ALU_SLTU;
               3'b100: alu_ctrl = ALU_XOR;
               3'b101: alu_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
               3'b110: alu_ctrl = ALU_OR;
               3'b111: alu_ctrl = ALU_AND;
               default: alu_ctrl = ALU_ADD;
            endcase
         end
         default: alu_ctrl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM with memory handshake.
// Define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN for a sticky illegal-op TRAP.
module multicycle_controller
   import multicycle_ctrl_pkg::*;
#(
   parameter int USE_MEM_READY = 1,
   parameter int ALU_CTRL_W    = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [6:0]            op,
   input  logic [2:0]            funct3,
   input  logic                  funct7b5,
   input  logic                  Zero,
   input  logic                  ALUR31,
   input  logic                  sltu,
   input  logic                  mem_ready,
   output logic                  PCWrite,
   output logic                  AdrSrc,
   output logic                  MemRead,
   output logic                  MemWrite,
   output logic                  IRWrite,
   output logic                  RegWrite,
   output logic [1:0]            ResultSrc,
   output logic [1:0]            ALUSrcA,
   output logic [1:0]            ALUSrcB,
   output logic [2:0]            ImmSrc,
   output logic [ALU_CTRL_W-1:0] ALUControl
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
   ,
   output logic                  illegal_o
`endif
);

   state_t     state;
   state_t     state_nx;
   aluop_t     aluop;
   logic [3:0] alu_code;
   logic       rdy;

   assign rdy = (USE_MEM_READY == 0) ? 1'b1 : mem_ready;

   always_ff @(posedge clk) begin
      if (reset) state <= S_FETCH;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      PCWrite   = 1'b0;
      AdrSrc    = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = RES_ALUOUT;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_RS2;
      aluop     = ALUOP_ADD;
      unique case (state)
         S_FETCH: begin
            MemRead   = 1'b1;
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            if (rdy) begin
               IRWrite  = 1'b1;
               PCWrite  = 1'b1;
               state_nx = S_DECODE;
            end
         end
         S_DECODE: begin
            // ALUOut captures OldPC + imm as branch/JAL target
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            unique case (op)
               OP_LOAD, OP_STORE: state_nx = S_MEMADR;
               OP_R:              state_nx = S_EXECR;
               OP_IMM:            state_nx = S_EXECI;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
               OP_BRANCH:
                  state_nx = (funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
`else
               OP_BRANCH:         state_nx = S_BRANCH;
`endif
               OP_JAL:            state_nx = S_JAL;
               OP_JALR:           state_nx = S_JALR;
               OP_LUI, OP_AUIPC:  state_nx = S_UPPER;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
               default:           state_nx = S_TRAP;
`else
               default:           state_nx = S_FETCH;
`endif
            endcase
         end
         S_MEMADR: begin
            ALUSrcA  = SRCA_RS1;
            ALUSrcB  = SRCB_IMM;
            state_nx = op[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            AdrSrc  = 1'b1;
            MemRead = 1'b1;
            if (rdy) state_nx = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            RegWrite  = 1'b1;
            state_nx  = S_FETCH;
         end
         S_MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
            if (rdy) state_nx = S_FETCH;
         end
         S_EXECR: begin
            ALUSrcA  = SRCA_RS1;
            ALUSrcB  = SRCB_RS2;
            aluop    = ALUOP_FUNCT;
            state_nx = S_ALUWB;
         end
         S_EXECI: begin
            ALUSrcA  = SRCA_RS1;
            ALUSrcB  = SRCB_IMM;
            aluop    = ALUOP_FUNCT;
            state_nx = S_ALUWB;
         end
         S_ALUWB: begin
            ResultSrc = RES_ALUOUT;
            RegWrite  = 1'b1;
            state_nx  = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA   = SRCA_RS1;
            ALUSrcB   = SRCB_RS2;
            aluop     = ALUOP_SUB;
            ResultSrc = RES_ALUOUT;
            PCWrite   = branch_taken(funct3, Zero, ALUR31, sltu);
            state_nx  = S_FETCH;
         end
         S_JAL: begin
            // PC takes ALUOut while ALU forms the link value
            ALUSrcA   = SRCA_OLDPC;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALUOUT;
            PCWrite   = 1'b1;
            state_nx  = S_ALUWB;
         end
         S_JALR: begin
            ALUSrcA  = SRCA_RS1;
            ALUSrcB  = SRCB_IMM;
            state_nx = S_JAL;
         end
         S_UPPER: begin
            ALUSrcA  = op[5] ? SRCA_ZERO : SRCA_OLDPC;
            ALUSrcB  = SRCB_IMM;
            state_nx = S_ALUWB;
         end
         S_TRAP: begin
            state_nx = S_TRAP;
         end
         default: begin
            state_nx = S_FETCH;
         end
      endcase
      // Abandon the instruction without any partial write
      if (reset) begin
         PCWrite   = 1'b0;
         AdrSrc    = 1'b0;
         MemRead   = 1'b0;
         MemWrite  = 1'b0;
         IRWrite   = 1'b0;
         RegWrite  = 1'b0;
         ResultSrc = RES_ALUOUT;
         ALUSrcA   = SRCA_PC;
         ALUSrcB   = SRCB_RS2;
         aluop     = ALUOP_ADD;
      end
   end

   always_comb begin
      ImmSrc = IMM_I;
      unique case (op)
         OP_LOAD, OP_IMM, OP_JALR: ImmSrc = IMM_I;
         OP_STORE:                 ImmSrc = IMM_S;
         OP_BRANCH:                ImmSrc = IMM_B;
         OP_JAL:                   ImmSrc = IMM_J;
         OP_LUI, OP_AUIPC:         ImmSrc = IMM_U;
         default:                  ImmSrc = IMM_I;
      endcase
   end

   mc_alu_decode u_alu_decode (
      .aluop    (aluop),
      .funct3   (funct3),
      .funct7b5 (funct7b5),
      .op5      (op[5]),
      .alu_ctrl (alu_code)
   );

   assign ALUControl = ALU_CTRL_W'(alu_code);

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
   assign illegal_o = (state == S_TRAP) && !reset;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller.
// Slots start 1 time unit after each rising edge.
module tb_multicycle_controller;
   import multicycle_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] op = 7'd0;
   logic [2:0] funct3 = 3'd0;
   logic       funct7b5 = 1'b0;
   logic       Zero = 1'b0;
   logic       ALUR31 = 1'b0;
   logic       sltu = 1'b0;
   logic       mem_ready = 1'b1;
   logic       PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
   logic [2:0] ImmSrc;
   logic [3:0] ALUControl;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
   logic       illegal_o;
`endif
   logic [5:0] strb;
   logic [5:0] mux;
   int         tests = 0;
   int         fails = 0;

   assign strb = {PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite};
   assign mux  = {ResultSrc, ALUSrcA, ALUSrcB};

   multicycle_controller #(
      .USE_MEM_READY (1),
      .ALU_CTRL_W    (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .Zero       (Zero),
      .ALUR31     (ALUR31),
      .sltu       (sltu),
      .mem_ready  (mem_ready),
      .PCWrite    (PCWrite),
      .AdrSrc     (AdrSrc),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .RegWrite   (RegWrite),
      .ResultSrc  (ResultSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ImmSrc     (ImmSrc),
      .ALUControl (ALUControl)
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      ,
      .illegal_o  (illegal_o)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // strb = {PCWrite,AdrSrc,MemRead,MemWrite,IRWrite,RegWrite}
   // mux  = {ResultSrc,ALUSrcA,ALUSrcB}
   task automatic test_reset;
      logic [6:0] ops[10] = '{7'b0000011, 7'b0010011, 7'b1100111,
         7'b0100011, 7'b1100011, 7'b1101111, 7'b0110111,
         7'b0010111, 7'b0000000, 7'b0110011};
      logic [2:0] imm[10] = '{3'b000, 3'b000, 3'b000, 3'b001,
         3'b010, 3'b011, 3'b100, 3'b100, 3'b000, 3'b000};
      reset = 1'b1;
      tick();
      tick();
      tests++;
      if (strb !== 6'b000000) begin
         fails++;
         $display("FAIL reset_strobes got %b exp 000000", strb);
      end
      tests++;
      if (mux !== 6'b000000 || ALUControl !== 4'b0000) begin
         fails++;
         $display("FAIL reset_selects got %b/%b exp 000000/0000",
                  mux, ALUControl);
      end
      tests++;
      if (dut.state !== S_FETCH) begin
         fails++;
         $display("FAIL reset_state got %0d exp %0d", dut.state, S_FETCH);
      end
      for (int i = 0; i < 10; i++) begin
         op = ops[i];
         #1;
         tests++;
         if (ImmSrc !== imm[i]) begin
            fails++;
            $display("FAIL immsrc op=%b got %b exp %b", ops[i], ImmSrc, imm[i]);
         end
      end
      op = 7'd0;
      reset = 1'b0;
   endtask

   task automatic test_reset_midwrite;
      state_t     es[4] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWRITE};
      logic [5:0] xs[4] = '{6'b101010, 6'b000000, 6'b000000, 6'b010100};
      logic [5:0] xm[4] = '{6'b100010, 6'b000101, 6'b001001, 6'b000000};
      op = OP_STORE;
      funct3 = 3'b010;
      for (int c = 0; c < 4; c++) begin
         mem_ready = (c < 3);
         #1;
         tests++;
         if (dut.state !== es[c] || strb !== xs[c] || mux !== xm[c]) begin
            fails++;
            $display("FAIL sw_slot%0d got st=%0d s=%b m=%b exp st=%0d s=%b m=%b",
                     c, dut.state, strb, mux, es[c], xs[c], xm[c]);
         end
         tick();
      end
      #1;
      tests++;
      if (dut.state !== S_MEMWRITE || MemWrite !== 1'b1) begin
         fails++;
         $display("FAIL sw_hold got st=%0d mw=%b exp st=%0d mw=1",
                  dut.state, MemWrite, S_MEMWRITE);
      end
      reset = 1'b1;
      for (int c = 0; c < 2; c++) begin
         #1;
         tests++;
         if (strb !== 6'b000000) begin
            fails++;
            $display("FAIL sw_reset%0d strobes got %b exp 000000", c, strb);
         end
         tick();
      end
      reset = 1'b0;
      mem_ready = 1'b1;
      #1;
      tests++;
      if (dut.state !== S_FETCH || RegWrite !== 1'b0) begin
         fails++;
         $display("FAIL sw_release got st=%0d rw=%b exp st=%0d rw=0",
                  dut.state, RegWrite, S_FETCH);
      end
   endtask

   task automatic test_alu_ops;
      logic [6:0] ops[5] = '{OP_R, OP_R, OP_IMM, OP_IMM, OP_R};
      logic [2:0] f3[5]  = '{3'b000, 3'b000, 3'b000, 3'b101, 3'b111};
      logic       f7[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [3:0] xa[5]  = '{4'b0000, 4'b0001, 4'b0000, 4'b1001, 4'b0010};
      state_t     es[4];
      logic [5:0] xs[4] = '{6'b101010, 6'b000000, 6'b000000, 6'b000001};
      logic [5:0] xm[4];
      for (int i = 0; i < 5; i++) begin
         op = ops[i];
         funct3 = f3[i];
         funct7b5 = f7[i];
         mem_ready = 1'b1;
         es = '{S_FETCH, S_DECODE, (ops[i] == OP_R) ? S_EXECR : S_EXECI, S_ALUWB};
         xm = '{6'b100010, 6'b000101,
                (ops[i] == OP_R) ? 6'b001000 : 6'b001001, 6'b000000};
         for (int c = 0; c < 4; c++) begin
            #1;
            tests++;
            if (dut.state !== es[c] || strb !== xs[c] || mux !== xm[c]) begin
               fails++;
               $display("FAIL alu%0d_slot%0d got st=%0d s=%b m=%b exp st=%0d s=%b m=%b",
                        i, c, dut.state, strb, mux, es[c], xs[c], xm[c]);
            end
            if (c == 2) begin
               tests++;
               if (ALUControl !== xa[i]) begin
                  fails++;
                  $display("FAIL alu%0d_ctrl got %b exp %b", i, ALUControl, xa[i]);
               end
            end
            tick();
         end
      end
      funct7b5 = 1'b0;
   endtask

   task automatic test_load_stall;
      state_t     es[8] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD,
                            S_MEMREAD, S_MEMREAD, S_MEMREAD, S_MEMWB};
      logic       rd[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [5:0] xs[8] = '{6'b101010, 6'b000000, 6'b000000, 6'b011000,
                            6'b011000, 6'b011000, 6'b011000, 6'b000001};
      logic [5:0] xm[8] = '{6'b100010, 6'b000101, 6'b001001, 6'b000000,
                            6'b000000, 6'b000000, 6'b000000, 6'b010000};
      op = OP_LOAD;
      funct3 = 3'b010;
      for (int c = 0; c < 8; c++) begin
         mem_ready = rd[c];
         #1;
         tests++;
         if (dut.state !== es[c] || strb !== xs[c] || mux !== xm[c]) begin
            fails++;
            $display("FAIL lw_cycle%0d got st=%0d s=%b m=%b exp st=%0d s=%b m=%b",
                     c + 1, dut.state, strb, mux, es[c], xs[c], xm[c]);
         end
         tick();
      end
      mem_ready = 1'b1;
   endtask

   task automatic test_fetch_stall_jal;
      state_t     es[6] = '{S_FETCH, S_FETCH, S_FETCH, S_DECODE, S_JAL, S_ALUWB};
      logic       rd[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [5:0] xs[6] = '{6'b001000, 6'b001000, 6'b101010,
                            6'b000000, 6'b100000, 6'b000001};
      logic [5:0] xm[6] = '{6'b100010, 6'b100010, 6'b100010,
                            6'b000101, 6'b000110, 6'b000000};
      op = OP_JAL;
      for (int c = 0; c < 6; c++) begin
         mem_ready = rd[c];
         #1;
         tests++;
         if (dut.state !== es[c] || strb !== xs[c] || mux !== xm[c]) begin
            fails++;
            $display("FAIL jal_slot%0d got st=%0d s=%b m=%b exp st=%0d s=%b m=%b",
                     c, dut.state, strb, mux, es[c], xs[c], xm[c]);
         end
         tick();
      end
      mem_ready = 1'b1;
   endtask

   task automatic test_branch;
      localparam int N = 8;
      logic [2:0] f3[N] = '{3'b110, 3'b110, 3'b001, 3'b000,
                            3'b100, 3'b101, 3'b111, 3'b010};
      logic       z[N]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic       lt[N] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic       lu[N] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic       tk[N] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      int         n;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      n = N - 1;
`else
      n = N;
`endif
      op = OP_BRANCH;
      mem_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         funct3 = f3[i];
         Zero = z[i];
         ALUR31 = lt[i];
         sltu = lu[i];
         #1;
         tests++;
         if (dut.state !== S_FETCH || strb !== 6'b101010) begin
            fails++;
            $display("FAIL br%0d_fetch got st=%0d s=%b exp st=%0d s=101010",
                     i, dut.state, strb, S_FETCH);
         end
         tick();
         tick();
         tests++;
         if (dut.state !== S_BRANCH || PCWrite !== tk[i]) begin
            fails++;
            $display("FAIL br%0d_taken got st=%0d pcw=%b exp st=%0d pcw=%b",
                     i, dut.state, PCWrite, S_BRANCH, tk[i]);
         end
         tests++;
         if (ALUControl !== 4'b0001 || mux !== 6'b001000 || RegWrite !== 1'b0) begin
            fails++;
            $display("FAIL br%0d_ctrl got alu=%b m=%b rw=%b exp 0001/001000/0",
                     i, ALUControl, mux, RegWrite);
         end
         tick();
      end
      #1;
      tests++;
      if (dut.state !== S_FETCH) begin
         fails++;
         $display("FAIL br_latency got st=%0d exp %0d", dut.state, S_FETCH);
      end
      Zero = 1'b0;
      ALUR31 = 1'b0;
      sltu = 1'b0;
   endtask

   task automatic test_jalr_upper;
      state_t     es[5] = '{S_FETCH, S_DECODE, S_JALR, S_JAL, S_ALUWB};
      logic [5:0] xs[5] = '{6'b101010, 6'b000000, 6'b000000,
                            6'b100000, 6'b000001};
      logic [5:0] xm[5] = '{6'b100010, 6'b000101, 6'b001001,
                            6'b000110, 6'b000000};
      logic [6:0] uo[2] = '{OP_LUI, OP_AUIPC};
      logic [5:0] um[2] = '{6'b001101, 6'b000101};
      op = OP_JALR;
      funct3 = 3'b000;
      mem_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         tests++;
         if (dut.state !== es[c] || strb !== xs[c] || mux !== xm[c]) begin
            fails++;
            $display("FAIL jalr_slot%0d got st=%0d s=%b m=%b exp st=%0d s=%b m=%b",
                     c, dut.state, strb, mux, es[c], xs[c], xm[c]);
         end
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         op = uo[i];
         tick();
         tick();
         tests++;
         if (dut.state !== S_UPPER || mux !== um[i] || strb !== 6'b000000) begin
            fails++;
            $display("FAIL upper%0d got st=%0d m=%b s=%b exp st=%0d m=%b s=000000",
                     i, dut.state, mux, strb, S_UPPER, um[i]);
         end
         tick();
         tests++;
         if (dut.state !== S_ALUWB || RegWrite !== 1'b1) begin
            fails++;
            $display("FAIL upper%0d_wb got st=%0d rw=%b exp st=%0d rw=1",
                     i, dut.state, RegWrite, S_ALUWB);
         end
         tick();
      end
   endtask

   task automatic test_illegal;
      op = 7'b0000000;
      mem_ready = 1'b1;
      #1;
      tests++;
      if (dut.state !== S_FETCH || IRWrite !== 1'b1) begin
         fails++;
         $display("FAIL ill_fetch got st=%0d irw=%b exp st=%0d irw=1",
                  dut.state, IRWrite, S_FETCH);
      end
      tick();
      tick();
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      for (int c = 0; c < 4; c++) begin
         tests++;
         if (dut.state !== S_TRAP || illegal_o !== 1'b1 || strb !== 6'b000000) begin
            fails++;
            $display("FAIL ill_trap%0d got st=%0d ill=%b s=%b exp st=%0d ill=1 s=000000",
                     c, dut.state, illegal_o, strb, S_TRAP);
         end
         tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      tests++;
      if (dut.state !== S_FETCH || illegal_o !== 1'b0) begin
         fails++;
         $display("FAIL ill_release got st=%0d ill=%b exp st=%0d ill=0",
                  dut.state, illegal_o, S_FETCH);
      end
`else
      tests++;
      if (dut.state !== S_FETCH || strb !== 6'b101010) begin
         fails++;
         $display("FAIL ill_nop got st=%0d s=%b exp st=%0d s=101010",
                  dut.state, strb, S_FETCH);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_reset_midwrite();
      test_alu_ops();
      test_load_stall();
      test_fetch_stall_jal();
      test_branch();
      test_jalr_upper();
      test_illegal();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
